// File: rtl/crc_frame_scheduler.sv
// Round-robin front end for a bit-serial CRC-16 encoder: arbitrates two word sources,
// streams the granted word MSB-first, and returns the captured remainder tagged by requester.
module crc_frame_scheduler #(
   parameter int DATA_LENGTH = 32,
   parameter int CRC_WIDTH   = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   req0_valid,
   input  logic [DATA_LENGTH-1:0] req0_data,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [DATA_LENGTH-1:0] req1_data,
   output logic                   req1_ready,
   output logic                   crc_start,
   output logic                   crc_data,
   input  logic [CRC_WIDTH-1:0]   crc_r,
   output logic                   res_valid,
   output logic [CRC_WIDTH-1:0]   res_crc,
   output logic                   res_id,
   input  logic                   res_ready
);

   localparam int               CNT_W     = $clog2(DATA_LENGTH + 2);
   localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(DATA_LENGTH + 1);
   localparam logic [CNT_W-1:0] SHIFT_CNT = CNT_W'(DATA_LENGTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_FLUSH,
      S_IDLE,
      S_START,
      S_SHIFT,
      S_CAPTURE,
      S_HOLD
   } state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   rr_last;
   logic [DATA_LENGTH-1:0] shift;
   logic                   grant0, grant1, accept;
   logic                   start_nxt, data_nxt, capture, consume, shift_en;

   // On a tie the requester that did not win last time is granted.
   assign grant0     = (state == S_IDLE) & req0_valid & (~req1_valid | rr_last);
   assign grant1     = (state == S_IDLE) & req1_valid & (~req0_valid | ~rr_last);
   assign accept     = grant0 | grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign shift_en   = (state == S_START) | (state == S_SHIFT);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      start_nxt = 1'b0;
      data_nxt  = 1'b0;
      capture   = 1'b0;
      consume   = 1'b0;
      case (state)
         S_FLUSH: begin
            if (cnt == CNT_ONE) state_nxt = S_IDLE;
            else                cnt_nxt   = cnt - CNT_ONE;
         end
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_START;
               start_nxt = 1'b1;
            end
         end
         S_START: begin
            state_nxt = S_SHIFT;
            cnt_nxt   = SHIFT_CNT;
            data_nxt  = shift[DATA_LENGTH-1];
         end
         S_SHIFT: begin
            if (cnt == CNT_ONE) begin
               state_nxt = S_CAPTURE;
            end else begin
               cnt_nxt  = cnt - CNT_ONE;
               data_nxt = shift[DATA_LENGTH-1];
            end
         end
         S_CAPTURE: begin
            state_nxt = S_HOLD;
            capture   = 1'b1;
         end
         S_HOLD: begin
            if (res_ready) begin
               state_nxt = S_IDLE;
               consume   = 1'b1;
            end
         end
         default: state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_FLUSH;
         cnt       <= FLUSH_CNT;
         rr_last   <= 1'b1;
         crc_start <= 1'b0;
         crc_data  <= 1'b0;
         res_valid <= 1'b0;
         res_crc   <= '0;
         res_id    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         crc_start <= start_nxt;
         crc_data  <= data_nxt;
         if (accept) begin
            rr_last <= grant1;
            res_id  <= grant1;
         end
         // crc_r is only meaningful in the capture cycle; the encoder reloads right after.
         if (capture) begin
            res_crc   <= crc_r;
            res_valid <= 1'b1;
         end else if (consume) begin
            res_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept)
         shift <= grant1 ? req1_data : req0_data;
      else if (shift_en)
         shift <= {shift[DATA_LENGTH-2:0], 1'b0};
   end

endmodule

// File: tb/tb_crc_frame_scheduler.sv
// Directed bench for crc_frame_scheduler with a behavioural bit-serial CRC-16 encoder
// and a stub mode that presents a marker remainder only in the capture cycle.
module tb_crc_frame_scheduler;

   localparam int DL = 32;
   localparam int CW = 16;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [DL-1:0] req0_data, req1_data;
   logic          crc_start, crc_data;
   logic [CW-1:0] crc_r;
   logic          res_valid, res_id, res_ready;
   logic [CW-1:0] res_crc;

   int checks = 0;
   int errors = 0;

   crc_frame_scheduler #(.DATA_LENGTH(DL), .CRC_WIDTH(CW)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .crc_start  (crc_start),
      .crc_data   (crc_data),
      .crc_r      (crc_r),
      .res_valid  (res_valid),
      .res_crc    (res_crc),
      .res_id     (res_id),
      .res_ready  (res_ready)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] crc_step(input logic [15:0] r, input logic b);
      logic fb;
      fb = r[15] ^ b;
      return {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction

   function automatic logic [15:0] golden(input logic [31:0] w);
      logic [15:0] r;
      r = 16'hFFFF;
      for (int i = 31; i >= 0; i--) r = crc_step(r, w[i]);
      return r;
   endfunction

   // Behavioural encoder: no reset, reload on start, then absorb DL serial bits.
   logic [15:0] enc_r = 16'h1234;
   int          enc_n = DL;
   logic [7:0]  since_start = 8'd0;
   logic        stub = 1'b0;

   always @(posedge clock) begin
      if (crc_start) begin
         enc_r <= 16'hFFFF;
         enc_n <= 0;
      end else if (enc_n < DL) begin
         enc_r <= crc_step(enc_r, crc_data);
         enc_n <= enc_n + 1;
      end
      if (crc_start)                                  since_start <= 8'd1;
      else if (since_start != 0 && since_start != 255) since_start <= since_start + 8'd1;
   end

   assign crc_r = stub ? ((since_start == 8'(DL + 1)) ? 16'hBEEF : 16'h0000) : enc_r;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called right after reset release with req0 pending; ends in the window where req0 is granted.
   task automatic flush_check();
      for (int i = 0; i < DL + 1; i++) begin
         chk("flush_ready", {31'b0, req0_ready}, 0);
         chk("flush_start", {31'b0, crc_start}, 0);
         @(posedge clock); #1;
      end
      chk("flush_end_ready", {31'b0, req0_ready}, 1);
   endtask

   task automatic send(input logic id, input logic [31:0] w);
      int n;
      n = 0;
      if (id) begin req1_data = w; req1_valid = 1'b1; end
      else    begin req0_data = w; req0_valid = 1'b1; end
      #1;
      while (n < 200 && !(id ? req1_ready : req0_ready)) begin
         @(posedge clock); #1;
         n++;
      end
      chk("accept_timeout", {31'b0, n < 200}, 1);
      @(posedge clock); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_res();
      int n;
      n = 0;
      while (n < 200 && !res_valid) begin
         @(posedge clock); #1;
         n++;
      end
      chk("result_timeout", {31'b0, n < 200}, 1);
   endtask

   task automatic consume();
      res_ready = 1'b1;
      @(posedge clock); #1;
      chk("consume_valid", {31'b0, res_valid}, 0);
      res_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic        gr[8];
      logic        rid[8];
      logic [15:0] rcrc[8];
      int          ng, nr, n;

      reset_n    = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 32'hA500_0001;
      req1_valid = 1'b0;
      req1_data  = '0;
      res_ready  = 1'b0;

      // Reset values and FLUSH
      repeat (3) @(posedge clock);
      #1;
      chk("rst_start", {31'b0, crc_start}, 0);
      chk("rst_data",  {31'b0, crc_data}, 0);
      chk("rst_valid", {31'b0, res_valid}, 0);
      chk("rst_crc",   {16'b0, res_crc}, 0);
      chk("rst_id",    {31'b0, res_id}, 0);
      chk("rst_ready", {30'b0, req1_ready, req0_ready}, 0);
      @(negedge clock);
      reset_n = 1'b1;
      flush_check();

      // Serial bit stream and latency for req0 0xA5000001 (accept happened in this window)
      w = 32'hA500_0001;
      @(posedge clock); #1;
      req0_valid = 1'b0;
      chk("start_strobe", {31'b0, crc_start}, 1);
      chk("start_data",   {31'b0, crc_data}, 0);
      for (int k = 0; k < DL; k++) begin
         @(posedge clock); #1;
         chk("shift_bit", {31'b0, crc_data}, {31'b0, w[31-k]});
      end
      chk("shift_no_start", {31'b0, crc_start}, 0);
      @(posedge clock); #1;
      chk("valid_before_latency", {31'b0, res_valid}, 0);
      @(posedge clock); #1;
      chk("valid_at_latency", {31'b0, res_valid}, 1);
      chk("a5_id",  {31'b0, res_id}, 0);
      chk("a5_crc", {16'b0, res_crc}, {16'b0, golden(w)});
      consume();

      // Stub remainder only in capture cycle, held under back-pressure
      stub = 1'b1;
      send(1'b0, 32'h0F0F_0F0F);
      wait_res();
      chk("stub_crc", {16'b0, res_crc}, 32'h0000_BEEF);
      chk("stub_id",  {31'b0, res_id}, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         chk("hold_valid", {31'b0, res_valid}, 1);
         chk("hold_crc",   {16'b0, res_crc}, 32'h0000_BEEF);
      end
      consume();
      stub = 1'b0;

      // Real encoder, req1 all-zero word
      send(1'b1, 32'h0000_0000);
      wait_res();
      chk("zero_id",  {31'b0, res_id}, 1);
      chk("zero_crc", {16'b0, res_crc}, {16'b0, golden(32'h0000_0000)});
      consume();

      // Both requesters continuously valid: alternating grants, no lost words
      req0_data  = 32'h1111_1111;
      req1_data  = 32'h2222_2222;
      res_ready  = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      ng = 0; nr = 0; n = 0;
      while (nr < 4 && n < 400) begin
         if (req0_ready && ng < 8) begin gr[ng] = 1'b0; ng++; end
         if (req1_ready && ng < 8) begin gr[ng] = 1'b1; ng++; end
         if (res_valid && nr < 8) begin rid[nr] = res_id; rcrc[nr] = res_crc; nr++; end
         @(posedge clock); #1;
         n++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b0;
      chk("rr_results", nr, 4);
      chk("rr_grants",  ng, 4);
      for (int i = 0; i < 4 && i < nr && i < ng; i++) begin
         chk("rr_grant_order", {31'b0, gr[i]}, i % 2);
         chk("rr_res_id",      {31'b0, rid[i]}, i % 2);
         chk("rr_res_crc",     {16'b0, rcrc[i]},
             {16'b0, golden((i % 2) != 0 ? 32'h2222_2222 : 32'h1111_1111)});
      end
      @(posedge clock); #1;

      // Reset pulsed mid-SHIFT
      send(1'b0, 32'h1234_5678);
      repeat (10) @(posedge clock);
      #1;
      req0_data  = 32'hCAFE_F00D;
      req0_valid = 1'b1;
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_start", {31'b0, crc_start}, 0);
      chk("midrst_data",  {31'b0, crc_data}, 0);
      chk("midrst_valid", {31'b0, res_valid}, 0);
      chk("midrst_ready", {31'b0, req0_ready}, 0);
      @(negedge clock);
      reset_n = 1'b1;
      flush_check();
      @(posedge clock); #1;
      req0_valid = 1'b0;
      wait_res();
      chk("post_rst_id",  {31'b0, res_id}, 0);
      chk("post_rst_crc", {16'b0, res_crc}, {16'b0, golden(32'hCAFE_F00D)});
      consume();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
